// File: rtl/wisc_pkg.sv
// Shared WISC-15 definitions: opcodes, instruction field positions, fetch
// state encoding and the fetch buffer depth.
// Build option: define FETCH_SKID_EN for a 2-entry fetch buffer (skid),
// otherwise the buffer holds a single entry.
package wisc_pkg;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LLB    = 4'hA;
    localparam logic [3:0] OP_LHB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

`ifdef FETCH_SKID_EN
    localparam logic [1:0] FETCH_DEPTH = 2'd2;
`else
    localparam logic [1:0] FETCH_DEPTH = 2'd1;
`endif

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// Small in-order buffer of fetched {inst, pc} pairs (1 or 2 entries in use).
// Flush has priority over push and pop. The caller never pushes when full
// and never pops when empty.
module fetch_buf #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [15:0]       i_inst,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic              o_valid,
    output logic [15:0]       o_inst,
    output logic [ADDR_W-1:0] o_pc,
    output logic [1:0]        o_occ
);

    logic [15:0]       r_head_inst;
    logic [ADDR_W-1:0] r_head_pc;
    logic [15:0]       r_tail_inst;
    logic [ADDR_W-1:0] r_tail_pc;
    logic [1:0]        r_cnt;
    logic              r_valid;
    logic [1:0]        w_cnt_nxt;

    // Next occupancy; the valid flag is registered from it so o_valid is a flop.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_flush) begin
            w_cnt_nxt = 2'd0;
        end else if (i_push && !i_pop) begin
            w_cnt_nxt = r_cnt + 2'd1;
        end else if (!i_push && i_pop) begin
            w_cnt_nxt = r_cnt - 2'd1;
        end
    end

    // Entry storage: head is always the oldest entry, tail only used when two are held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head_inst <= '0;
            r_head_pc   <= '0;
            r_tail_inst <= '0;
            r_tail_pc   <= '0;
            r_cnt       <= 2'd0;
            r_valid     <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_valid <= (w_cnt_nxt != 2'd0);
            if (!i_flush) begin
                case ({i_push, i_pop})
                    2'b10: begin
                        if (r_cnt == 2'd0) begin
                            r_head_inst <= i_inst;
                            r_head_pc   <= i_pc;
                        end else begin
                            r_tail_inst <= i_inst;
                            r_tail_pc   <= i_pc;
                        end
                    end
                    2'b01: begin
                        if (r_cnt == 2'd2) begin
                            r_head_inst <= r_tail_inst;
                            r_head_pc   <= r_tail_pc;
                        end
                    end
                    2'b11: begin
                        if (r_cnt == 2'd2) begin
                            r_head_inst <= r_tail_inst;
                            r_head_pc   <= r_tail_pc;
                            r_tail_inst <= i_inst;
                            r_tail_pc   <= i_pc;
                        end else begin
                            r_head_inst <= i_inst;
                            r_head_pc   <= i_pc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_valid = r_valid;
    assign o_inst  = r_head_inst;
    assign o_pc    = r_head_pc;
    assign o_occ   = r_cnt;

endmodule

// File: rtl/fetch_unit.sv
// WISC-15 instruction fetch stage: owns the PC, keeps at most one word read
// outstanding, buffers returned words and stops on an issued hlt.
// Build option: FETCH_SKID_EN selects the 2-entry buffer (see wisc_pkg).
//
// Handshakes: memory request is imem_req/imem_addr, held stable until
// imem_rdy is sampled high (same-cycle rdy counts); decode transfer happens
// on any rising edge where inst_valid and inst_ready are both high.
module fetch_unit
    import wisc_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rdy,
    input  logic [15:0]       imem_data,
    output logic [15:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);

    fetch_state_e      r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic              r_pend, w_pend_nxt;
    logic              r_drop, w_drop_nxt;

    logic              w_run, w_pop, w_hlt_seen, w_redir, w_halt_go;
    logic              w_accept, w_push, w_flush, w_pend_hold;
    logic [1:0]        w_occ, w_occ_nxt;

    // State registers; reset abandons any in-flight memory request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
            r_pend  <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_addr  <= w_addr_nxt;
            r_pend  <= w_pend_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    // Next-state: redirect beats a same-cycle hlt, and any response arriving
    // with a redirect (or marked for drop) is discarded.
    always_comb begin
        w_run       = (r_state == RUN);
        w_pop       = inst_valid & inst_ready;
        w_hlt_seen  = w_pop & (inst[OPC_MSB:OPC_LSB] == OP_HLT);
        w_redir     = w_run & redirect;
        w_halt_go   = w_hlt_seen & w_run & ~w_redir;
        w_accept    = r_pend & imem_rdy;
        w_push      = w_accept & ~r_drop & ~w_redir & ~w_halt_go;
        w_flush     = w_redir | w_halt_go;
        w_pend_hold = r_pend & ~imem_rdy;

        w_occ_nxt = w_occ;
        if (w_flush) begin
            w_occ_nxt = 2'd0;
        end else if (w_push && !w_pop) begin
            w_occ_nxt = w_occ + 2'd1;
        end else if (!w_push && w_pop) begin
            w_occ_nxt = w_occ - 2'd1;
        end

        w_pc_nxt = r_pc;
        if (w_redir) begin
            w_pc_nxt = redirect_pc;
        end else if (w_push) begin
            w_pc_nxt = r_addr + ADDR_W'(1);
        end

        w_drop_nxt = r_drop;
        if (w_halt_go) begin
            w_drop_nxt = 1'b0;
        end else if (w_redir) begin
            w_drop_nxt = w_pend_hold;
        end else if (w_accept) begin
            w_drop_nxt = 1'b0;
        end

        // A new request is launched only when nothing stays outstanding and
        // the buffer will still have room counting that request.
        w_pend_nxt = w_pend_hold;
        w_addr_nxt = r_addr;
        if (w_halt_go) begin
            w_pend_nxt = 1'b0;
        end else if (!w_pend_hold && w_run && (w_occ_nxt < FETCH_DEPTH)) begin
            w_pend_nxt = 1'b1;
            w_addr_nxt = w_pc_nxt;
        end

        w_state_nxt = w_halt_go ? HALTED : r_state;
    end

    fetch_buf #(.ADDR_W(ADDR_W)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_inst  (imem_data),
        .i_pc    (r_addr),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_valid (inst_valid),
        .o_inst  (inst),
        .o_pc    (inst_pc),
        .o_occ   (w_occ)
    );

    assign imem_req  = r_pend & (r_state == RUN);
    assign imem_addr = r_addr;
    assign halted    = (r_state == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a simple wait-state memory model.
module tb_fetch_unit;

`ifdef FETCH_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_data;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halted;

  fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdy    (imem_rdy),
    .imem_data   (imem_data),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halted      (halted)
  );

  // ---------------- memory model ----------------
  int   mem_lat = 0;
  int   lat_cnt = 0;
  logic hlt_en  = 1'b0;

  always @(posedge clk) lat_cnt <= (imem_req && !imem_rdy) ? lat_cnt + 1 : 0;

  assign imem_rdy  = imem_req && (lat_cnt >= mem_lat);
  assign imem_data = (hlt_en && imem_addr == 16'h0003) ? 16'hF000
                                                       : (16'h0123 ^ {4'h0, imem_addr[11:0]});

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (hlt_en && a == 16'h0003) return 16'hF000;
    return 16'h0123 ^ {4'h0, a[11:0]};
  endfunction

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int data_err = 0;
  int pc4_issued = 0;
  logic hlt_iss = 1'b0;
  logic [15:0] acc_q[$];
  logic [15:0] iss_q[$];
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Log the handshakes that the coming rising edge will act on, then move
  // to the following falling edge.
  task automatic cyc();
    if (imem_req && imem_rdy) acc_q.push_back(imem_addr);
    if (inst_valid && inst_ready) begin
      iss_q.push_back(inst_pc);
      if (inst_pc == 16'h0004) pc4_issued++;
      if (inst_pc == 16'h0003 && inst[15:12] == 4'hF) hlt_iss = 1'b1;
    end
    if (inst_valid && inst !== mem_word(inst_pc)) data_err++;
    @(negedge clk);
  endtask

  task automatic clear_logs();
    acc_q.delete();
    iss_q.delete();
    hlt_iss = 1'b0;
  endtask

  task automatic cmp_acc(input string tag);
    for (int i = 0; i < exp_q.size(); i++)
      check(tag, 32'(i < acc_q.size() ? acc_q[i] : 16'hxxxx), 32'(exp_q[i]));
  endtask

  task automatic cmp_iss(input string tag);
    for (int i = 0; i < exp_q.size(); i++)
      check(tag, 32'(i < iss_q.size() ? iss_q[i] : 16'hxxxx), 32'(exp_q[i]));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic        found;
    logic [15:0] h_inst;
    logic [15:0] h_pc;
    int          viol;

    @(negedge clk);
    cyc();
    // Reset values
    check("rst_req",    32'(imem_req),   32'd0);
    check("rst_addr",   32'(imem_addr),  32'h0000);
    check("rst_inst",   32'(inst),       32'h0000);
    check("rst_pc",     32'(inst_pc),    32'h0000);
    check("rst_valid",  32'(inst_valid), 32'd0);
    check("rst_halted", 32'(halted),     32'd0);

    // Zero-wait streaming from address 0
    clear_logs();
    rst = 1'b0;
    cyc();
    check("t1_first_req",  32'(imem_req),   32'd1);
    check("t1_first_addr", 32'(imem_addr),  32'h0000);
    check("t1_no_valid",   32'(inst_valid), 32'd0);
    cyc();
    check("t1_valid", 32'(inst_valid), 32'd1);
    check("t1_inst",  32'(inst),       32'h0123);
    check("t1_pc",    32'(inst_pc),    32'h0000);
    repeat (10) cyc();
    exp_q = '{16'h0000, 16'h0001, 16'h0002, 16'h0003};
    cmp_acc("t1_addr_seq");
    cmp_iss("t1_issue_seq");

    // Decode stall for 5 cycles
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (inst_valid) begin found = 1'b1; break; end
      cyc();
    end
    check("t2_head_valid", 32'(found), 32'd1);
    h_pc   = 16'(iss_q.size());
    h_inst = mem_word(h_pc);
    inst_ready = 1'b0;
    viol = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("t2_head_hold", {inst, inst_pc}, {h_inst, h_pc});
      if (acc_q.size() - iss_q.size() > DEPTH) viol++;
    end
    check("t2_valid_hold", 32'(inst_valid), 32'd1);
    check("t2_over_cap",   32'(viol), 32'd0);
    check("t2_occupancy",  32'(acc_q.size() - iss_q.size()), 32'(DEPTH));
    check("t2_no_req",     32'(imem_req), 32'd0);
    inst_ready = 1'b1;

    // 3-cycle memory, redirect while the request to 4 is outstanding
    rst = 1'b1;
    mem_lat = 2;
    cyc();
    check("rst_mid_req", 32'(imem_req), 32'd0);
    cyc();
    clear_logs();
    pc4_issued = 0;
    rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (imem_req && imem_addr == 16'h0004) begin found = 1'b1; break; end
      cyc();
    end
    check("t3_reach_req4", 32'(found), 32'd1);
    cyc();
    check("t3_req4_c2", {15'd0, imem_req, imem_addr}, {15'd0, 1'b1, 16'h0004});
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    cyc();
    redirect = 1'b0;
    check("t3_hold_req",  32'(imem_req),  32'd1);
    check("t3_hold_addr", 32'(imem_addr), 32'h0004);
    cyc();
    check("t3_flushed",    32'(inst_valid), 32'd0);
    check("t3_redir_req",  32'(imem_req),   32'd1);
    check("t3_redir_addr", 32'(imem_addr),  32'h0040);
    repeat (16) cyc();
    exp_q = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0040, 16'h0041};
    cmp_acc("t3_addr_seq");
    exp_q = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0040, 16'h0041};
    cmp_iss("t3_issue_seq");
    check("t3_no_pc4", 32'(pc4_issued), 32'd0);

    // hlt at address 3
    rst = 1'b1;
    mem_lat = 0;
    hlt_en = 1'b1;
    cyc();
    cyc();
    clear_logs();
    rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (hlt_iss) begin found = 1'b1; break; end
    end
    check("t4_hlt_consumed", 32'(found),      32'd1);
    check("t4_halted",       32'(halted),     32'd1);
    check("t4_valid_off",    32'(inst_valid), 32'd0);
    check("t4_req_off",      32'(imem_req),   32'd0);
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (imem_req || !halted) viol++;
    end
    check("t4_stay_halted", 32'(viol), 32'd0);
    redirect = 1'b1;
    redirect_pc = 16'h0020;
    cyc();
    redirect = 1'b0;
    cyc();
    check("t4_redir_ignored", {imem_req, halted}, 32'b01);
    rst = 1'b1;
    cyc();
    check("t4_rst_clears", 32'(halted), 32'd0);

    // hlt consumed together with a redirect
    cyc();
    clear_logs();
    rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (inst_valid && inst_pc == 16'h0003) begin found = 1'b1; break; end
      cyc();
    end
    check("t5_hlt_at_head", 32'(found), 32'd1);
    redirect = 1'b1;
    redirect_pc = 16'h0010;
    cyc();
    redirect = 1'b0;
    check("t5_not_halted", 32'(halted), 32'd0);
    check("t5_req",        {15'd0, imem_req, imem_addr}, {15'd0, 1'b1, 16'h0010});
    clear_logs();
    repeat (6) cyc();
    check("t5_still_run", 32'(halted), 32'd0);
    exp_q = '{16'h0010, 16'h0011};
    cmp_acc("t5_addr_seq");
    exp_q = '{16'h0010};
    cmp_iss("t5_issue_seq");

    // Redirect to the top of the address space
    rst = 1'b1;
    hlt_en = 1'b0;
    cyc();
    cyc();
    clear_logs();
    rst = 1'b0;
    repeat (5) cyc();
    redirect = 1'b1;
    redirect_pc = 16'hFFFF;
    cyc();
    redirect = 1'b0;
    clear_logs();
    repeat (10) cyc();
    exp_q = '{16'hFFFF, 16'h0000, 16'h0001};
    cmp_acc("t6_wrap_addr");
    exp_q = '{16'hFFFF, 16'h0000};
    cmp_iss("t6_wrap_issue");

    check("data_match", 32'(data_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
